lepes_dekoder: RTL
==================

// Module: lepes_dekoder
// PURPOSE
//  Receive-side counterpart of the stepper coil drivers: watches the 4-bit coil pattern on tekercsek,
//  recovers step events, direction, drive mode and an absolute position in half-steps.
//  Sits between the coil bus and the supervisor logic. Used as a position monitor and a fault detector
//  for any of the three drive schemes: single-coil full step, two-coil full step and half step.
// PARAMETERS
//  POS_W    16    width of signed position counter (half-step units)
//  STABIL   2     cycles a synchronized pattern must be unchanged before it is accepted (>=1)
//  TIMEOUT  1000  stall window in clk cycles (used only with LEPES_ELAKADAS_EN)
// PORTS
//  clk         in   1      single clock, all logic on posedge
//  rst         in   1      asynchronous, active-high reset
//  tekercsek   in   4      coil pattern, asynchronous to clk
//  hiba_torol  in   1      clears sticky error; ERROR -> IDLE
//  lepes       out  1      one-cycle pulse per accepted step
//  irany       out  1      direction of last step: 1 = forward (ascending phase), 0 = backward
//  pozicio     out  POS_W  signed position, half-steps
//  mod         out  2      00 unknown, 01 single-coil full, 10 two-coil full, 11 half step
//  aktiv       out  1      1 while in LOCKED
//  hiba        out  1      sticky fault flag
//  elakadas    out  1      stall flag (tied 0 when LEPES_ELAKADAS_EN is undefined)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, phase register 0, filter counter 0.
//  Input: 2-FF synchronizer, then stability filter.
//  - The pattern is accepted when it has been equal for STABIL consecutive cycles.
//  - Any change restarts the count.
//  Phase map: 0001=0, 0011=1, 0010=2, 0110=3, 0100=4, 1100=5, 1000=6, 1001=7.
//  - 0000 = idle.
//  - Every other pattern is illegal.
//  Latency: a held input change shows on the outputs 2+STABIL+1 cycles after it is applied.
//  FSM, evaluated only on the cycle a new pattern is accepted:
//  - IDLE:
//    - valid phase -> LOCKED, store phase, no step, pozicio unchanged.
//    - 0000 -> stay in IDLE.
//    - illegal pattern -> ERROR.
//  - LOCKED: d = (new - old) mod 8.
//    - d=1 or 2: lepes=1, irany=1, pozicio += d.
//    - d=7 or 6: lepes=1, irany=0, pozicio -= (8-d).
//    - d=3, 4 or 5: missed step -> ERROR.
//    - illegal pattern -> ERROR.
//    - 0000 -> IDLE; pozicio, irany and mod are kept.
//  - ERROR: hiba=1, pozicio frozen, input ignored.
//    - hiba_torol=1 -> IDLE, hiba=0.
//    - If hiba_torol and a new error occur in the same cycle, the error wins and hiba stays 1.
//  mod is updated on every step:
//  - |delta|=1 -> 11.
//  - |delta|=2 with even phase -> 01.
//  - |delta|=2 with odd phase -> 10.
//  pozicio wraps in two's complement, with no saturation.
//  Reset asserted mid-operation clears everything immediately, including the synchronizers.
// CONFIGURATION
//  LEPES_ELAKADAS_EN defined:
//  - A counter runs while in LOCKED and clears on each lepes.
//  - Reaching TIMEOUT sets elakadas=1, which holds until the next lepes, IDLE, ERROR or rst.
//  LEPES_ELAKADAS_EN undefined: no counter is built and elakadas=0 constantly.
// STRUCTURE
//  Package lepes_pkg holds:
//  - phase pattern constants (the 8 codes plus IDLE);
//  - the FSM state enum (IDLE, LOCKED, ERROR);
//  - the mod encoding constants;
//  - the function fazis_kod(pattern) -> {valid, idle, phase[2:0]}.
//  One sub-module, fazis_szuro: synchronizer plus stability filter, producing the accepted pattern and a new-pattern strobe.
//  The top level holds the FSM, the position arithmetic and the optional stall counter.
// TESTING
//  (STABIL=2, POS_W=16; each input pattern held 6 cycles)
//  1. rst pulse mid-sequence -> all outputs 0 on the next cycle; state IDLE.
//  2. Half-step forward 0001,0011,0010,0110,0100,1100,1000,1001,0001
//     -> 8 lepes pulses, pozicio=8, irany=1, mod=11, aktiv=1.
//  3. Single-coil backward 0001,1000,0100,0010
//     -> 3 pulses, pozicio=-6 (0xFFFA), irany=0, mod=01.
//  4. Glitch: stable 0001, then 1 cycle of 0010, then 0001 -> no lepes, pozicio unchanged.
//  5. Skip 0001->0100 -> hiba=1, aktiv=0, pozicio frozen.
//     Then hiba_torol=1 for 1 cycle -> hiba=0, IDLE.
//     Then 0011 -> LOCKED with no step.
//  6. LEPES_ELAKADAS_EN, TIMEOUT=20: hold 0011 in LOCKED for 25 cycles -> elakadas=1 at count 20.
//     Next step 0110 -> elakadas=0.

Source files
------------

// File: rtl/lepes_pkg.sv
// rtl/lepes_pkg.sv - coil phase codes, FSM states and mode encoding for lepes_dekoder
package lepes_pkg;

  localparam logic [3:0] MINTA_URES = 4'b0000;
  localparam logic [3:0] MINTA_F0   = 4'b0001;
  localparam logic [3:0] MINTA_F1   = 4'b0011;
  localparam logic [3:0] MINTA_F2   = 4'b0010;
  localparam logic [3:0] MINTA_F3   = 4'b0110;
  localparam logic [3:0] MINTA_F4   = 4'b0100;
  localparam logic [3:0] MINTA_F5   = 4'b1100;
  localparam logic [3:0] MINTA_F6   = 4'b1000;
  localparam logic [3:0] MINTA_F7   = 4'b1001;

  typedef enum logic [1:0] {
    ALL_IDLE   = 2'd0,
    ALL_LOCKED = 2'd1,
    ALL_ERROR  = 2'd2
  } allapot_t;

  localparam logic [1:0] MOD_ISMERETLEN = 2'b00;
  localparam logic [1:0] MOD_EGY        = 2'b01;
  localparam logic [1:0] MOD_KETTO      = 2'b10;
  localparam logic [1:0] MOD_FEL        = 2'b11;

  // Result packs as {valid, idle, phase[2:0]}; illegal patterns are all-zero.
  function automatic logic [4:0] fazis_kod(input logic [3:0] minta);
    logic [4:0] kod;
    case (minta)
      MINTA_F0:   kod = 5'b10_000;
      MINTA_F1:   kod = 5'b10_001;
      MINTA_F2:   kod = 5'b10_010;
      MINTA_F3:   kod = 5'b10_011;
      MINTA_F4:   kod = 5'b10_100;
      MINTA_F5:   kod = 5'b10_101;
      MINTA_F6:   kod = 5'b10_110;
      MINTA_F7:   kod = 5'b10_111;
      MINTA_URES: kod = 5'b01_000;
      default:    kod = 5'b00_000;
    endcase
    return kod;
  endfunction

endpackage

// File: rtl/fazis_szuro.sv
// rtl/fazis_szuro.sv - 2-FF synchronizer and stability filter for the coil pattern
module fazis_szuro #(
  parameter int STABIL = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_minta,
  output logic [3:0] o_elfogadott,
  output logic       o_uj
);

  localparam int CW = $clog2(STABIL + 1);

  logic [3:0]    r_s1, r_s2, r_jelolt, r_elfogadott;
  logic [CW-1:0] r_cnt;
  logic          r_uj;
  logic          w_valtozott, w_elfogad;
  logic [CW-1:0] w_cnt_next;

  assign w_valtozott = (r_s2 != r_jelolt);
  assign w_cnt_next  = w_valtozott ? CW'(1) :
                       (r_cnt == CW'(STABIL)) ? r_cnt : r_cnt + CW'(1);
  // Strobe only when a stable pattern differs from the one already accepted.
  assign w_elfogad   = (w_cnt_next == CW'(STABIL)) && (r_s2 != r_elfogadott);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_jelolt     <= '0;
      r_cnt        <= '0;
      r_elfogadott <= '0;
      r_uj         <= 1'b0;
    end else begin
      r_s1     <= i_minta;
      r_s2     <= r_s1;
      r_jelolt <= r_s2;
      r_cnt    <= w_cnt_next;
      r_uj     <= w_elfogad;
      if (w_elfogad) r_elfogadott <= r_s2;
    end
  end

  assign o_elfogadott = r_elfogadott;
  assign o_uj         = r_uj;

endmodule

// File: rtl/lepes_dekoder.sv
// rtl/lepes_dekoder.sv - stepper coil pattern decoder: steps, direction, mode, position
// Optional stall detector enabled by LEPES_ELAKADAS_EN.
module lepes_dekoder
  import lepes_pkg::*;
#(
  parameter int POS_W   = 16,
  parameter int STABIL  = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_tekercsek,
  input  logic             i_hiba_torol,
  output logic             o_lepes,
  output logic             o_irany,
  output logic [POS_W-1:0] o_pozicio,
  output logic [1:0]       o_mod,
  output logic             o_aktiv,
  output logic             o_hiba,
  output logic             o_elakadas
);

  logic [3:0]       w_minta;
  logic             w_uj;
  logic [4:0]       w_kod;
  logic [2:0]       w_fazis, w_d;

  allapot_t         r_allapot, w_allapot_next;
  logic [2:0]       r_fazis, w_fazis_next;
  logic             r_lepes, w_lepes_next;
  logic             r_irany, w_irany_next;
  logic [POS_W-1:0] r_pozicio, w_pozicio_next;
  logic [1:0]       r_mod, w_mod_next;

  fazis_szuro #(.STABIL(STABIL)) u_szuro (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_minta      (i_tekercsek),
    .o_elfogadott (w_minta),
    .o_uj         (w_uj)
  );

  assign w_kod   = fazis_kod(w_minta);
  assign w_fazis = w_kod[2:0];
  assign w_d     = w_fazis - r_fazis;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_allapot <= ALL_IDLE;
      r_fazis   <= '0;
      r_lepes   <= 1'b0;
      r_irany   <= 1'b0;
      r_pozicio <= '0;
      r_mod     <= MOD_ISMERETLEN;
    end else begin
      r_allapot <= w_allapot_next;
      r_fazis   <= w_fazis_next;
      r_lepes   <= w_lepes_next;
      r_irany   <= w_irany_next;
      r_pozicio <= w_pozicio_next;
      r_mod     <= w_mod_next;
    end
  end

  always_comb begin
    w_allapot_next = r_allapot;
    w_fazis_next   = r_fazis;
    w_lepes_next   = 1'b0;
    w_irany_next   = r_irany;
    w_pozicio_next = r_pozicio;
    w_mod_next     = r_mod;
    case (r_allapot)
      ALL_IDLE: begin
        if (w_uj) begin
          if (w_kod[4]) begin
            w_allapot_next = ALL_LOCKED;
            w_fazis_next   = w_fazis;
          end else if (!w_kod[3]) begin
            w_allapot_next = ALL_ERROR;
          end
        end
      end
      ALL_LOCKED: begin
        if (w_uj) begin
          if (w_kod[3]) begin
            w_allapot_next = ALL_IDLE;
          end else if (!w_kod[4]) begin
            w_allapot_next = ALL_ERROR;
          end else if (w_d == 3'd1 || w_d == 3'd2 || w_d == 3'd6 || w_d == 3'd7) begin
            // w_d read as signed 3-bit gives the step: +1, +2, -2, -1.
            w_fazis_next   = w_fazis;
            w_lepes_next   = 1'b1;
            w_irany_next   = ~w_d[2];
            w_pozicio_next = r_pozicio + {{(POS_W-3){w_d[2]}}, w_d};
            w_mod_next     = (w_d == 3'd1 || w_d == 3'd7) ? MOD_FEL :
                             (w_fazis[0] ? MOD_KETTO : MOD_EGY);
          end else if (w_d != 3'd0) begin
            w_allapot_next = ALL_ERROR;
          end
        end
      end
      ALL_ERROR: begin
        if (i_hiba_torol) w_allapot_next = ALL_IDLE;
      end
      default: w_allapot_next = ALL_IDLE;
    endcase
  end

  assign o_lepes   = r_lepes;
  assign o_irany   = r_irany;
  assign o_pozicio = r_pozicio;
  assign o_mod     = r_mod;
  assign o_aktiv   = (r_allapot == ALL_LOCKED);
  assign o_hiba    = (r_allapot == ALL_ERROR);

`ifdef LEPES_ELAKADAS_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_elak_cnt;
  logic          r_elakadas;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_elak_cnt <= '0;
      r_elakadas <= 1'b0;
    end else if (w_allapot_next != ALL_LOCKED || w_lepes_next) begin
      r_elak_cnt <= '0;
      r_elakadas <= 1'b0;
    end else if (r_elak_cnt != TW'(TIMEOUT)) begin
      r_elak_cnt <= r_elak_cnt + TW'(1);
      if (r_elak_cnt == TW'(TIMEOUT - 1)) r_elakadas <= 1'b1;
    end
  end

  assign o_elakadas = r_elakadas;
`else
  assign o_elakadas = 1'b0 && (TIMEOUT > 0);
`endif

endmodule
